vga_frame_switch: RTL

- Parametrised N-source VGA output selector.
- Sits between the per-mode video generators (ready / game / over screens and any later ones) and the VGA pins.
- Unlike a plain per-cycle mux, it changes source only on a frame boundary of the current source. It then inserts a configurable number of blanked frames, so the monitor never sees a torn frame or a broken sync train.
- A timeout forces the switch if the current source has stopped producing vsync.

---
 rtl/vga_pkg.sv | 39 +++
 rtl/vga_frame_switch_if.sv | 31 +++
 rtl/vga_frame_edge_det.sv | 40 ++++
 rtl/vga_frame_switch.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA mode selectors: switch FSM states, sync
// polarity constants and a one-hot request decoder.
package vga_pkg;

  typedef enum logic [1:0] {
    LOCKED  = 2'd0,
    PENDING = 2'd1,
    BLANK   = 2'd2
  } sw_state_e;

  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

  localparam int MAX_SRC = 32;
  localparam int IDX_W   = $clog2(MAX_SRC);

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } onehot_idx_t;

  // valid only when exactly one bit is set; idx is zero otherwise
  function automatic onehot_idx_t onehot_to_idx(input logic [MAX_SRC-1:0] vec);
    onehot_idx_t res;
    int unsigned ones;
    res  = '0;
    ones = 0;
    for (int i = 0; i < MAX_SRC; i++) begin
      if (vec[i]) begin
        ones++;
        res.idx = IDX_W'(i);
      end
    end
    res.valid = (ones == 1);
    if (!res.valid) res.idx = '0;
    return res;
  endfunction

endpackage

// File: rtl/vga_frame_switch_if.sv
// Source-side and pin-side signals of the VGA frame switch.
interface vga_frame_switch_if #(
  parameter int NUM_SRC = 3,
  parameter int COLOR_W = 1
);
  localparam int SEL_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]         mode_req;
  logic [NUM_SRC-1:0]         src_hsync;
  logic [NUM_SRC-1:0]         src_vsync;
  logic [NUM_SRC*COLOR_W-1:0] src_red;
  logic [NUM_SRC*COLOR_W-1:0] src_green;
  logic [NUM_SRC*COLOR_W-1:0] src_blue;
  logic                       hsync_out;
  logic                       vsync_out;
  logic [COLOR_W-1:0]         red_out;
  logic [COLOR_W-1:0]         green_out;
  logic [COLOR_W-1:0]         blue_out;
  logic [SEL_W-1:0]           active_sel;
  logic                       switch_busy;

  modport slave (
    input  mode_req, src_hsync, src_vsync, src_red, src_green, src_blue,
    output hsync_out, vsync_out, red_out, green_out, blue_out, active_sel, switch_busy
  );

  modport master (
    output mode_req, src_hsync, src_vsync, src_red, src_green, src_blue,
    input  hsync_out, vsync_out, red_out, green_out, blue_out, active_sel, switch_busy
  );
endinterface

// File: rtl/vga_frame_edge_det.sv
// Vsync leading-edge detector for the watched source plus the saturating
// frame-timeout counter used by the switch FSM.
module vga_frame_edge_det #(
  parameter logic SYNC_POL    = 1'b0,
  parameter int   TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic vs_in,
  input  logic reload,
  input  logic reload_vs,
  input  logic cnt_clr,
  input  logic cnt_en,
  output logic lead_edge,
  output logic timeout
);
  localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(TIMEOUT_CYC - 1);

  logic             vs_prev;
  logic [CNT_W-1:0] cnt;

  // reload swaps history to the new source so its current level is not seen as an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         vs_prev <= ~SYNC_POL;
    else if (reload) vs_prev <= reload_vs;
    else             vs_prev <= vs_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          cnt <= '0;
    else if (cnt_clr)                 cnt <= '0;
    else if (cnt_en && cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
  end

  assign lead_edge = (vs_in == SYNC_POL) && (vs_prev == ~SYNC_POL);
  assign timeout   = (cnt == CNT_FIRE);

endmodule

// File: rtl/vga_frame_switch.sv
// N-source VGA selector that changes source only on a vsync leading edge of
// the current source, then blanks RGB for a number of frames of the new one.
module vga_frame_switch
  import vga_pkg::*;
#(
  parameter int   NUM_SRC      = 3,
  parameter int   COLOR_W      = 1,
  parameter logic SYNC_POL     = 1'b0,
  parameter int   DEFAULT_SRC  = 0,
  parameter int   BLANK_FRAMES = 1,
  parameter int   TIMEOUT_CYC  = 1000000
) (
  input logic               clk,
  input logic               rst,
  vga_frame_switch_if.slave sw
);
  localparam int               SEL_W   = $clog2(NUM_SRC);
  localparam int               BW      = (BLANK_FRAMES > 0) ? $clog2(BLANK_FRAMES + 1) : 1;
  localparam logic [SEL_W-1:0] DEF_SEL = SEL_W'(DEFAULT_SRC);
  localparam logic [BW-1:0]    BF_LAST = BW'(BLANK_FRAMES - 1);

  logic [MAX_SRC-1:0] req_ext;
  onehot_idx_t        req_dec;
  logic [SEL_W-1:0]   dec_idx;

  sw_state_e        state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] tgt_q, tgt_d;
  logic [BW-1:0]    blank_cnt_q, blank_cnt_d;
  logic             busy_q;

  logic lead_edge, timeout, cnt_clr, cnt_en, reload, reload_vs, watch_vs, rgb_mask;

  always_comb begin
    req_ext                = '0;
    req_ext[NUM_SRC-1:0]   = sw.mode_req;
    req_dec                = onehot_to_idx(req_ext);
    dec_idx                = req_dec.valid ? SEL_W'(req_dec.idx) : DEF_SEL;
  end

  assign watch_vs  = sw.src_vsync[sel_q];
  assign reload_vs = sw.src_vsync[sel_d];

  vga_frame_edge_det #(
    .SYNC_POL    (SYNC_POL),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_edge_det (
    .clk       (clk),
    .rst       (rst),
    .vs_in     (watch_vs),
    .reload    (reload),
    .reload_vs (reload_vs),
    .cnt_clr   (cnt_clr),
    .cnt_en    (cnt_en),
    .lead_edge (lead_edge),
    .timeout   (timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOCKED;
      sel_q       <= DEF_SEL;
      tgt_q       <= DEF_SEL;
      blank_cnt_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      tgt_q       <= tgt_d;
      blank_cnt_q <= blank_cnt_d;
      busy_q      <= (state_d != LOCKED);
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    tgt_d       = tgt_q;
    blank_cnt_d = blank_cnt_q;
    case (state_q)
      LOCKED: begin
        if (dec_idx != sel_q) begin
          tgt_d   = dec_idx;
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (dec_idx == sel_q) begin
          state_d = LOCKED;
        end else begin
          tgt_d = dec_idx;
          if (lead_edge || timeout) begin
            sel_d       = tgt_d;
            blank_cnt_d = '0;
            state_d     = (BLANK_FRAMES == 0) ? LOCKED : BLANK;
          end
        end
      end
      BLANK: begin
        if (lead_edge) begin
          blank_cnt_d = blank_cnt_q + BW'(1);
          if (blank_cnt_q == BF_LAST) state_d = LOCKED;
        end else if (timeout) begin
          state_d = LOCKED;
        end
      end
      default: state_d = LOCKED;
    endcase
  end

  always_comb begin
    cnt_en   = (state_q != LOCKED);
    cnt_clr  = (state_q == LOCKED) || (state_d != state_q) || ((state_q == BLANK) && lead_edge);
    reload   = (state_q == PENDING) && (sel_d != sel_q);
    rgb_mask = (state_q == BLANK);
  end

  // p1: registered output stage, fed from the source selected before any switch this cycle
  logic               hsync_p1, vsync_p1;
  logic [COLOR_W-1:0] red_p1, green_p1, blue_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_p1 <= ~SYNC_POL;
      vsync_p1 <= ~SYNC_POL;
      red_p1   <= '0;
      green_p1 <= '0;
      blue_p1  <= '0;
    end else begin
      hsync_p1 <= sw.src_hsync[sel_q];
      vsync_p1 <= sw.src_vsync[sel_q];
      red_p1   <= rgb_mask ? '0 : sw.src_red[int'(sel_q)*COLOR_W +: COLOR_W];
      green_p1 <= rgb_mask ? '0 : sw.src_green[int'(sel_q)*COLOR_W +: COLOR_W];
      blue_p1  <= rgb_mask ? '0 : sw.src_blue[int'(sel_q)*COLOR_W +: COLOR_W];
    end
  end

  assign sw.hsync_out   = hsync_p1;
  assign sw.vsync_out   = vsync_p1;
  assign sw.red_out     = red_p1;
  assign sw.green_out   = green_p1;
  assign sw.blue_out    = blue_p1;
  assign sw.active_sel  = sel_q;
  assign sw.switch_busy = busy_q;

endmodule
